// File: rtl/i2c_target_if.sv
// Register-file side of the I2C target: pointer, write/read strobes, read data and bus status.
interface i2c_target_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       nack_seen;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re, busy, nack_seen,
        input  reg_rdata
    );
    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re, busy, nack_seen,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target: START/STOP decode, 7-bit address match, auto-incrementing 8-bit register pointer.
module i2c_target #(
    parameter logic [6:0]  C_DEV_ADDR    = 7'h1A,
    parameter int unsigned C_SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         scl,
    inout  wire          sda,
    i2c_target_if.master rf
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_t;

    logic [C_SYNC_STAGES-1:0] scl_sync_r;
    logic [C_SYNC_STAGES-1:0] sda_sync_r;
    logic       scl_d_r, sda_d_r;
    logic       scl_s, sda_s, rise_s, fall_s, start_s, stop_s, addr_match_s;

    state_t     state_r, state_nx_s;
    logic [3:0] bit_cnt_r, bit_cnt_nx_s;
    logic [7:0] shift_r, shift_nx_s;
    logic       rw_r, rw_nx_s;
    logic       first_r, first_nx_s;
    logic       ack_ok_r, ack_ok_nx_s;
    logic       rd_load_r, rd_load_nx_s;
    logic       sda_oe_r, sda_oe_nx_s;
    logic [7:0] reg_addr_r, reg_addr_nx_s;
    logic [7:0] reg_wdata_r, reg_wdata_nx_s;
    logic       reg_we_r, reg_we_nx_s;
    logic       reg_re_r, reg_re_nx_s;
    logic       busy_r, busy_nx_s;
    logic       nack_r, nack_nx_s;

    // Input synchronizers plus one delay stage for edge detection; an idle bus reads high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {C_SYNC_STAGES{1'b1}};
            sda_sync_r <= {C_SYNC_STAGES{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[C_SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[C_SYNC_STAGES-2:0], sda};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    assign scl_s   = scl_sync_r[C_SYNC_STAGES-1];
    assign sda_s   = sda_sync_r[C_SYNC_STAGES-1];
    assign rise_s  = scl_s & ~scl_d_r;
    assign fall_s  = ~scl_s & scl_d_r;
    // SCL must be high on both samples so an SDA change coincident with SCL falling is not a condition.
    assign start_s = scl_s & scl_d_r & ~sda_s & sda_d_r;
    assign stop_s  = scl_s & scl_d_r & sda_s & ~sda_d_r;
    assign addr_match_s = (shift_r[7:1] == C_DEV_ADDR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode: bus conditions win over bit/ack progress.
    always_comb begin
        state_nx_s = state_r;
        if (stop_s) begin
            state_nx_s = ST_IDLE;
        end else if (start_s) begin
            state_nx_s = ST_ADDR;
        end else begin
            case (state_r)
                ST_IDLE:     state_nx_s = ST_IDLE;
                ST_ADDR:     if (fall_s && bit_cnt_r == 4'd8) state_nx_s = addr_match_s ? ST_ADDR_ACK : ST_IDLE;
                             else state_nx_s = ST_ADDR;
                ST_ADDR_ACK: if (fall_s) state_nx_s = rw_r ? ST_RD_BYTE : ST_WR_BYTE;
                             else state_nx_s = ST_ADDR_ACK;
                ST_WR_BYTE:  if (fall_s && bit_cnt_r == 4'd8) state_nx_s = ST_WR_ACK;
                             else state_nx_s = ST_WR_BYTE;
                ST_WR_ACK:   if (fall_s) state_nx_s = ST_WR_BYTE;
                             else state_nx_s = ST_WR_ACK;
                ST_RD_BYTE:  if (fall_s && bit_cnt_r == 4'd8) state_nx_s = ST_RD_ACK;
                             else state_nx_s = ST_RD_BYTE;
                ST_RD_ACK:   if (rise_s && sda_s) state_nx_s = ST_IDLE;
                             else if (fall_s && ack_ok_r) state_nx_s = ST_RD_BYTE;
                             else state_nx_s = ST_RD_ACK;
                default:     state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values; strobes default low every cycle.
    always_comb begin
        bit_cnt_nx_s   = bit_cnt_r;
        shift_nx_s     = shift_r;
        rw_nx_s        = rw_r;
        first_nx_s     = first_r;
        ack_ok_nx_s    = ack_ok_r;
        rd_load_nx_s   = reg_re_r;
        sda_oe_nx_s    = sda_oe_r;
        reg_addr_nx_s  = reg_we_r ? (reg_addr_r + 8'd1) : reg_addr_r;
        reg_wdata_nx_s = reg_wdata_r;
        reg_we_nx_s    = 1'b0;
        reg_re_nx_s    = 1'b0;
        busy_nx_s      = busy_r;
        nack_nx_s      = 1'b0;
        if (stop_s) begin
            sda_oe_nx_s = 1'b0;
            busy_nx_s   = 1'b0;
        end else if (start_s) begin
            sda_oe_nx_s  = 1'b0;
            bit_cnt_nx_s = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_nx_s = 4'd0;
                end
                ST_ADDR, ST_WR_BYTE: begin
                    if (rise_s) begin
                        shift_nx_s   = {shift_r[6:0], sda_s};
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end else if (fall_s && bit_cnt_r == 4'd8) begin
                        bit_cnt_nx_s = 4'd0;
                        if (state_r == ST_ADDR) begin
                            rw_nx_s     = shift_r[0];
                            sda_oe_nx_s = addr_match_s;
                            busy_nx_s   = busy_r | addr_match_s;
                        end else if (first_r) begin
                            sda_oe_nx_s   = 1'b1;
                            reg_addr_nx_s = shift_r;
                            first_nx_s    = 1'b0;
                        end else begin
                            sda_oe_nx_s    = 1'b1;
                            reg_wdata_nx_s = shift_r;
                            reg_we_nx_s    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r;
                    end
                end
                ST_ADDR_ACK: begin
                    if (fall_s) begin
                        sda_oe_nx_s  = 1'b0;
                        bit_cnt_nx_s = 4'd0;
                        reg_re_nx_s  = rw_r;
                        first_nx_s   = ~rw_r;
                    end else begin
                        sda_oe_nx_s = sda_oe_r;
                    end
                end
                ST_WR_ACK: begin
                    if (fall_s) begin
                        sda_oe_nx_s = 1'b0;
                    end else begin
                        sda_oe_nx_s = sda_oe_r;
                    end
                end
                ST_RD_BYTE: begin
                    // Read data lands one cycle after the strobe; MSB goes out as soon as it is loaded.
                    if (rd_load_r) begin
                        shift_nx_s   = rf.reg_rdata;
                        sda_oe_nx_s  = ~rf.reg_rdata[7];
                        bit_cnt_nx_s = 4'd1;
                    end else if (fall_s && bit_cnt_r == 4'd8) begin
                        sda_oe_nx_s  = 1'b0;
                        bit_cnt_nx_s = 4'd0;
                        ack_ok_nx_s  = 1'b0;
                    end else if (fall_s) begin
                        sda_oe_nx_s  = ~shift_r[6];
                        shift_nx_s   = {shift_r[6:0], 1'b0};
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end else begin
                        sda_oe_nx_s = sda_oe_r;
                    end
                end
                ST_RD_ACK: begin
                    if (rise_s && sda_s) begin
                        nack_nx_s = 1'b1;
                    end else if (rise_s) begin
                        ack_ok_nx_s   = 1'b1;
                        reg_addr_nx_s = reg_addr_r + 8'd1;
                    end else if (fall_s && ack_ok_r) begin
                        reg_re_nx_s  = 1'b1;
                        ack_ok_nx_s  = 1'b0;
                        bit_cnt_nx_s = 4'd0;
                    end else begin
                        ack_ok_nx_s = ack_ok_r;
                    end
                end
                default: begin
                    sda_oe_nx_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'd0;
            rw_r        <= 1'b0;
            first_r     <= 1'b0;
            ack_ok_r    <= 1'b0;
            rd_load_r   <= 1'b0;
            sda_oe_r    <= 1'b0;
            reg_addr_r  <= 8'd0;
            reg_wdata_r <= 8'd0;
            reg_we_r    <= 1'b0;
            reg_re_r    <= 1'b0;
            busy_r      <= 1'b0;
            nack_r      <= 1'b0;
        end else begin
            bit_cnt_r   <= bit_cnt_nx_s;
            shift_r     <= shift_nx_s;
            rw_r        <= rw_nx_s;
            first_r     <= first_nx_s;
            ack_ok_r    <= ack_ok_nx_s;
            rd_load_r   <= rd_load_nx_s;
            sda_oe_r    <= sda_oe_nx_s;
            reg_addr_r  <= reg_addr_nx_s;
            reg_wdata_r <= reg_wdata_nx_s;
            reg_we_r    <= reg_we_nx_s;
            reg_re_r    <= reg_re_nx_s;
            busy_r      <= busy_nx_s;
            nack_r      <= nack_nx_s;
        end
    end

    assign sda          = sda_oe_r ? 1'b0 : 1'bz;
    assign rf.reg_addr  = reg_addr_r;
    assign rf.reg_wdata = reg_wdata_r;
    assign rf.reg_we    = reg_we_r;
    assign rf.reg_re    = reg_re_r;
    assign rf.busy      = busy_r;
    assign rf.nack_seen = nack_r;
endmodule

// File: tb/tb_i2c_target.sv
// Randomized bench for i2c_target: bit-level I2C master, register file, and a transaction-level model.
module tb_i2c_target;
    localparam int         H   = 12;
    localparam logic [6:0] DEV = 7'h1A;

    logic clk;
    logic rst;
    logic scl_m;
    logic sda_low;
    wire  sda_w;

    i2c_target_if rif ();

    pullup (sda_w);
    assign sda_w = sda_low ? 1'b0 : 1'bz;

    i2c_target #(.C_DEV_ADDR(DEV), .C_SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .scl(scl_m),
        .sda(sda_w),
        .rf (rif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: reset contents are addr + 0x10, read data appears the clock after reg_re.
    logic [7:0] rf_mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) rf_mem[i] <= 8'(i + 16);
            rif.reg_rdata <= 8'h00;
        end else begin
            if (rif.reg_we) rf_mem[rif.reg_addr] <= rif.reg_wdata;
            if (rif.reg_re) rif.reg_rdata <= rf_mem[rif.reg_addr];
        end
    end

    // Strobe monitor, sampled mid-cycle.
    logic [15:0] wr_seen_q [$];
    int re_cnt   = 0;
    int nack_cnt = 0;
    always @(negedge clk) begin
        if (rif.reg_we) wr_seen_q.push_back({rif.reg_addr, rif.reg_wdata});
        if (rif.reg_re) re_cnt++;
        if (rif.nack_seen) nack_cnt++;
    end

    // Transaction-level reference model.
    logic [7:0]  exp_mem [256];
    logic [7:0]  ptr_m;
    logic [15:0] exp_wr_q [$];
    int exp_re   = 0;
    int exp_nack = 0;
    int wr_idx   = 0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ptr_m = 8'h00;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i + 16);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        sda_low = ~b;
        wait_cyc(H); scl_m = 1'b1;
        wait_cyc(H); scl_m = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        sda_low = 1'b0;
        wait_cyc(H); scl_m = 1'b1;
        wait_cyc(H / 2); b = sda_w;
        wait_cyc(H - H / 2); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        sda_low = 1'b0; wait_cyc(H);
        scl_m = 1'b1;   wait_cyc(H);
        sda_low = 1'b1; wait_cyc(H);
        scl_m = 1'b0;   wait_cyc(H);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; wait_cyc(H);
        scl_m = 1'b1;   wait_cyc(H);
        sda_low = 1'b0; wait_cyc(H);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic nak);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(nak);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nak);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nak);
    endtask

    task automatic check_writes();
        chk("wr_count", 32'(wr_seen_q.size()), 32'(exp_wr_q.size()));
        chk("re_count", 32'(re_cnt), 32'(exp_re));
        while (wr_idx < exp_wr_q.size() && wr_idx < wr_seen_q.size()) begin
            chk("wr_addr_data", 32'(wr_seen_q[wr_idx]), 32'(exp_wr_q[wr_idx]));
            wr_idx++;
        end
    endtask

    task automatic do_write(input logic [6:0] a7, input logic [7:0] ptr,
                            input logic [7:0] d [4], input int n);
        logic nak;
        bus_start();
        send_byte({a7, 1'b0}, nak);
        chk("addr_ack", 32'(nak), (a7 == DEV) ? 32'd0 : 32'd1);
        chk("busy_addr", 32'(rif.busy), (a7 == DEV) ? 32'd1 : 32'd0);
        if (a7 == DEV) begin
            send_byte(ptr, nak);
            chk("ptr_ack", 32'(nak), 32'd0);
            ptr_m = ptr;
            for (int k = 0; k < n; k++) begin
                send_byte(d[k], nak);
                chk("data_ack", 32'(nak), 32'd0);
                exp_mem[ptr_m] = d[k];
                exp_wr_q.push_back({ptr_m, d[k]});
                ptr_m = ptr_m + 8'd1;
            end
        end
        bus_stop();
        chk("busy_stop", 32'(rif.busy), 32'd0);
        check_writes();
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
        logic       nak;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            send_byte({DEV, 1'b0}, nak);
            chk("rdp_addr_ack", 32'(nak), 32'd0);
            send_byte(ptr, nak);
            chk("rdp_ptr_ack", 32'(nak), 32'd0);
            ptr_m = ptr;
            bus_start();
        end
        send_byte({DEV, 1'b1}, nak);
        chk("rd_addr_ack", 32'(nak), 32'd0);
        for (int k = 0; k < n; k++) begin
            recv_byte(d, k == n - 1);
            chk("rd_data", 32'(d), 32'(exp_mem[ptr_m]));
            exp_re++;
            if (k != n - 1) ptr_m = ptr_m + 8'd1;
        end
        exp_nack++;
        chk("busy_after_nack", 32'(rif.busy), 32'd1);
        bus_stop();
        chk("busy_stop", 32'(rif.busy), 32'd0);
        chk("nack_count", 32'(nack_cnt), 32'(exp_nack));
        check_writes();
    endtask

    initial begin
        logic       nak;
        logic [7:0] dv [4];
        logic [6:0] bad;
        int         kind;

        rst = 1'b1; scl_m = 1'b1; sda_low = 1'b0;
        wait_cyc(3);
        chk("rst_busy",  32'(rif.busy),      32'd0);
        chk("rst_we",    32'(rif.reg_we),    32'd0);
        chk("rst_re",    32'(rif.reg_re),    32'd0);
        chk("rst_nack",  32'(rif.nack_seen), 32'd0);
        chk("rst_addr",  32'(rif.reg_addr),  32'd0);
        chk("rst_wdata", 32'(rif.reg_wdata), 32'd0);
        chk("rst_sda",   32'(sda_w),         32'd1);
        rst = 1'b0;
        model_reset();
        wait_cyc(4);

        dv[0] = 8'hA5; dv[1] = 8'h5A; dv[2] = 8'h00; dv[3] = 8'h00;
        do_write(DEV, 8'h05, dv, 2);
        do_write(7'h1B, 8'h00, dv, 0);
        do_read(1'b1, 8'h10, 3);
        dv[0] = 8'h11; dv[1] = 8'h22;
        do_write(DEV, 8'hFF, dv, 2);

        // Reset while the master is mid data byte, then a fresh transaction.
        bus_start();
        send_byte(8'h34, nak);
        chk("mid_addr_ack", 32'(nak), 32'd0);
        send_byte(8'h30, nak);
        chk("mid_ptr_ack", 32'(nak), 32'd0);
        bit_out(1'b1); bit_out(1'b1); bit_out(1'b0); bit_out(1'b0);
        sda_low = 1'b0;
        rst = 1'b1;
        wait_cyc(1);
        chk("midrst_sda",  32'(sda_w),    32'd1);
        chk("midrst_busy", 32'(rif.busy), 32'd0);
        rst = 1'b0;
        model_reset();
        wait_cyc(2);
        dv[0] = 8'h99;
        do_write(DEV, 8'h40, dv, 1);

        // SDA glitches with SCL low, then STOP in the middle of a byte.
        bus_start();
        send_byte(8'h34, nak);
        chk("gl_addr_ack", 32'(nak), 32'd0);
        send_byte(8'h50, nak);
        chk("gl_ptr_ack", 32'(nak), 32'd0);
        ptr_m = 8'h50;
        bit_out(1'b1); bit_out(1'b0);
        for (int g = 0; g < 3; g++) begin
            sda_low = 1'b0; wait_cyc(2);
            sda_low = 1'b1; wait_cyc(2);
        end
        bit_out(1'b1);
        chk("gl_busy", 32'(rif.busy), 32'd1);
        bus_stop();
        chk("gl_stop_busy", 32'(rif.busy), 32'd0);
        check_writes();
        do_read(1'b0, 8'h00, 1);

        for (int it = 0; it < 14; it++) begin
            kind = int'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) dv[k] = 8'($urandom);
            case (kind)
                0: do_write(DEV, 8'($urandom), dv, int'($urandom_range(1, 3)));
                1: do_read(1'b1, 8'($urandom), int'($urandom_range(1, 3)));
                2: do_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
                default: begin
                    bad = 7'($urandom);
                    if (bad == DEV) bad = bad ^ 7'h01;
                    do_write(bad, 8'h00, dv, 2);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
